// File: rtl/pair_judge_pkg.sv
// Shared definitions for the memory-game pair judge: tile colours, states and
// the BCD/one-hot helpers used by the judge datapath.
package tile_pkg;

    localparam int         NUM_TILES   = 10;
    localparam logic [9:0] ALL_MATCHED = 10'h3FF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ONE   = 2'd1,
        JUDGE = 2'd2,
        DONE  = 2'd3
    } judge_state_t;

    function automatic logic [3:0] tile_color(input logic [3:0] idx);
        case (idx)
            4'd0:    tile_color = 4'd1;
            4'd1:    tile_color = 4'd2;
            4'd2:    tile_color = 4'd3;
            4'd3:    tile_color = 4'd4;
            4'd4:    tile_color = 4'd2;
            4'd5:    tile_color = 4'd4;
            4'd6:    tile_color = 4'd3;
            4'd7:    tile_color = 4'd1;
            4'd8:    tile_color = 4'd5;
            4'd9:    tile_color = 4'd5;
            default: tile_color = 4'd0;
        endcase
    endfunction

    function automatic logic [9:0] tile_bit(input logic [3:0] idx);
        if (idx <= 4'd9) begin
            tile_bit = 10'd1 << idx;
        end else begin
            tile_bit = 10'd0;
        end
    endfunction

    // Two-digit BCD increment that holds at 99.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99) begin
            bcd_inc = v;
        end else if (v[3:0] == 4'd9) begin
            bcd_inc = {v[7:4] + 4'd1, 4'd0};
        end else begin
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/pair_judge_if.sv
// Tile-pick handshake between the pick stage (master) and the pair judge (slave).
interface pair_judge_if;
    logic       pick_valid;
    logic [3:0] pick_idx;
    logic       pick_ready;

    modport master (output pick_valid, output pick_idx, input pick_ready);
    modport slave  (input pick_valid, input pick_idx, output pick_ready);
endinterface

// File: rtl/pair_judge_blink_timer.sv
// Blink timer for the judging window: BLINKS on/off pairs of BLINK_HALF cycles.
// phase_on is the phase of the coming cycle so the caller can register outputs with it.
module blink_timer #(
    parameter int BLINK_HALF = 12_500_000,
    parameter int BLINKS     = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic phase_on,
    output logic done
);
    localparam int HW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int NW = (2 * BLINKS > 1) ? $clog2(2 * BLINKS) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(BLINK_HALF - 1);
    localparam logic [NW-1:0] NUM_LAST  = NW'(2 * BLINKS - 1);

    logic          running_r, running_s;
    logic [HW-1:0] half_cnt_r, half_cnt_s;
    logic [NW-1:0] half_num_r, half_num_s;
    logic          phase_r, phase_s;
    logic          done_r, done_s;

    // Next-state counters; a fresh start always restarts from the first on half.
    always_comb begin
        running_s  = running_r;
        half_cnt_s = half_cnt_r;
        half_num_s = half_num_r;
        phase_s    = phase_r;
        if (clear) begin
            running_s  = 1'b0;
            half_cnt_s = '0;
            half_num_s = '0;
            phase_s    = 1'b0;
        end else if (start) begin
            running_s  = 1'b1;
            half_cnt_s = '0;
            half_num_s = '0;
            phase_s    = 1'b1;
        end else if (running_r) begin
            if (half_cnt_r == HALF_LAST) begin
                half_cnt_s = '0;
                if (half_num_r == NUM_LAST) begin
                    running_s  = 1'b0;
                    half_num_s = '0;
                    phase_s    = 1'b0;
                end else begin
                    half_num_s = half_num_r + 1'b1;
                    phase_s    = ~phase_r;
                end
            end else begin
                half_cnt_s = half_cnt_r + 1'b1;
            end
        end else begin
            running_s = 1'b0;
        end
        done_s = running_s && (half_cnt_s == HALF_LAST) && (half_num_s == NUM_LAST);
    end

    // Counter and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_r  <= 1'b0;
            half_cnt_r <= '0;
            half_num_r <= '0;
            phase_r    <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            running_r  <= running_s;
            half_cnt_r <= half_cnt_s;
            half_num_r <= half_num_s;
            phase_r    <= phase_s;
            done_r     <= done_s;
        end
    end

    assign phase_on = phase_s;
    assign done     = done_r;
endmodule

// File: rtl/pair_judge.sv
// Pair judge: holds two revealed tiles, blinks them, then locks or flips them back,
// keeping a saturating BCD move score and the game-over flag.
module pair_judge
    import tile_pkg::*;
#(
    parameter int BLINK_HALF = 12_500_000,
    parameter int BLINKS     = 3,
    parameter int NUM_TILES  = tile_pkg::NUM_TILES
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 quit,
    pair_judge_if.slave          pick,
    output logic [NUM_TILES-1:0] face_up,
    output logic [NUM_TILES-1:0] matched,
    output logic [3:0]           color1,
    output logic [3:0]           color2,
    output logic [7:0]           move_bcd,
    output logic                 game_over
);
    judge_state_t state_r, state_s;
    logic [3:0]  first_idx_r, first_idx_s;
    logic [3:0]  second_idx_r, second_idx_s;
    logic [9:0]  revealed_r, revealed_s;
    logic [9:0]  matched_r, matched_s;
    logic [7:0]  move_bcd_r, move_bcd_s;
    logic [9:0]  face_up_r, face_up_s;
    logic [3:0]  color1_r, color1_s;
    logic [3:0]  color2_r, color2_s;
    logic        pick_ready_r, pick_ready_s;
    logic        game_over_r, game_over_s;
    logic [15:0] matched_ext_s;
    logic        accept_s;
    logic        start_s;
    logic        show_s;
    logic        phase_on_s;
    logic        timer_done_s;

    blink_timer #(
        .BLINK_HALF(BLINK_HALF),
        .BLINKS    (BLINKS)
    ) u_blink_timer (
        .clk     (CLOCK_50),
        .reset   (reset),
        .start   (start_s),
        .clear   (quit),
        .phase_on(phase_on_s),
        .done    (timer_done_s)
    );

    // Pick acceptance, FSM transitions and next values of every registered output.
    always_comb begin
        matched_ext_s = {6'd0, matched_r};
        accept_s = pick.pick_valid && pick_ready_r && (pick.pick_idx <= 4'd9)
                   && (matched_ext_s[pick.pick_idx] == 1'b0)
                   && ((state_r != ONE) || (pick.pick_idx != first_idx_r));
        state_s      = state_r;
        first_idx_s  = first_idx_r;
        second_idx_s = second_idx_r;
        revealed_s   = revealed_r;
        matched_s    = matched_r;
        move_bcd_s   = move_bcd_r;
        start_s      = 1'b0;
        if (quit) begin
            state_s      = IDLE;
            first_idx_s  = 4'd0;
            second_idx_s = 4'd0;
            revealed_s   = 10'd0;
            matched_s    = 10'd0;
            move_bcd_s   = 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        first_idx_s = pick.pick_idx;
                        revealed_s  = revealed_r | tile_bit(pick.pick_idx);
                        state_s     = ONE;
                    end else begin
                        state_s = IDLE;
                    end
                end
                ONE: begin
                    if (accept_s) begin
                        second_idx_s = pick.pick_idx;
                        revealed_s   = revealed_r | tile_bit(pick.pick_idx);
                        state_s      = JUDGE;
                        start_s      = 1'b1;
                    end else begin
                        state_s = ONE;
                    end
                end
                JUDGE: begin
                    if (timer_done_s) begin
                        if (tile_color(first_idx_r) == tile_color(second_idx_r)) begin
                            matched_s = matched_r | tile_bit(first_idx_r) | tile_bit(second_idx_r);
                        end else begin
                            matched_s = matched_r;
                        end
                        revealed_s = 10'd0;
                        move_bcd_s = bcd_inc(move_bcd_r);
                        state_s    = (matched_s == ALL_MATCHED) ? DONE : IDLE;
                    end else begin
                        state_s = JUDGE;
                    end
                end
                DONE:    state_s = DONE;
                default: state_s = IDLE;
            endcase
        end

        // Outside JUDGE the revealed tiles are shown steadily.
        show_s       = (state_s != JUDGE) || phase_on_s;
        pick_ready_s = (state_s == IDLE) || (state_s == ONE);
        game_over_s  = (state_s == DONE);
        if (state_s == DONE) begin
            face_up_s = ALL_MATCHED;
        end else begin
            face_up_s = matched_s | (revealed_s & {10{show_s}});
        end
        case (state_s)
            ONE: begin
                color1_s = tile_color(first_idx_s);
                color2_s = 4'd0;
            end
            JUDGE: begin
                color1_s = show_s ? tile_color(first_idx_s) : 4'd0;
                color2_s = show_s ? tile_color(second_idx_s) : 4'd0;
            end
            default: begin
                color1_s = 4'd0;
                color2_s = 4'd0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r      <= IDLE;
            first_idx_r  <= 4'd0;
            second_idx_r <= 4'd0;
            revealed_r   <= 10'd0;
            matched_r    <= 10'd0;
            move_bcd_r   <= 8'd0;
            face_up_r    <= 10'd0;
            color1_r     <= 4'd0;
            color2_r     <= 4'd0;
            pick_ready_r <= 1'b1;
            game_over_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            first_idx_r  <= first_idx_s;
            second_idx_r <= second_idx_s;
            revealed_r   <= revealed_s;
            matched_r    <= matched_s;
            move_bcd_r   <= move_bcd_s;
            face_up_r    <= face_up_s;
            color1_r     <= color1_s;
            color2_r     <= color2_s;
            pick_ready_r <= pick_ready_s;
            game_over_r  <= game_over_s;
        end
    end

    assign pick.pick_ready = pick_ready_r;
    assign face_up         = face_up_r;
    assign matched         = matched_r;
    assign color1          = color1_r;
    assign color2          = color2_r;
    assign move_bcd        = move_bcd_r;
    assign game_over       = game_over_r;
endmodule
